// File: rtl/vga_vram_pkg.sv
// Shared definitions for the VGA frame store: bus beat field positions and memory-map constants.
// Imported by the interface, the top and the testbench so every bus slice is taken from one place.
package vga_vram_pkg;

    localparam int MOSI_W   = 36;
    localparam int HW_W     = 16;

    localparam int RW_BIT   = 35;
    localparam int DATA_HI  = 34;
    localparam int DATA_LO  = 19;
    localparam int ADDR_HI  = 18;

    localparam logic RW_WRITE = 1'b1;

    // Byte window the system bus decodes to this block before it reaches cs_n.
    localparam logic [31:0] VGA_WIN_BASE = 32'hA000_0000;
    localparam logic [31:0] VGA_WIN_SIZE = 32'h0010_0000;

endpackage

// File: rtl/vga_vram_if.sv
// Bus-side beat port plus scan-out port of the frame store.
// master = bus/pixel-timing side, slave = vga_vram.
interface vga_vram_if;
    import vga_vram_pkg::*;

    logic              cs_n;
    logic [MOSI_W-1:0] mosi;
    logic [HW_W-1:0]   miso;
    logic              pix_en;
    logic [HW_W-1:0]   pix_data;
    logic              frame_start;

    modport master (
        output cs_n, mosi, pix_en,
        input  miso, pix_data, frame_start
    );

    modport slave (
        input  cs_n, mosi, pix_en,
        output miso, pix_data, frame_start
    );

endinterface

// File: rtl/vram_dp.sv
// Simple dual-port synchronous RAM: port A read/write (write-first), port B read-only (read-old).
// Contents are never reset; outputs are registered, one cycle latency on both ports.
module vram_dp #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdat,
    output logic [DW-1:0] a_rdat,
    input  logic          b_en,
    input  logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_rdat
);

    logic [DW-1:0] mem [2**AW];

    // Port B samples mem before port A's non-blocking write lands, giving read-old on a collision.
    always_ff @(posedge clk) begin
        if (a_en) begin
            if (a_we) begin
                mem[a_addr] <= a_wdat;
                a_rdat      <= a_wdat;
            end else begin
                a_rdat      <= mem[a_addr];
            end
        end
        if (b_en) begin
            b_rdat <= mem[b_addr];
        end
    end

endmodule

// File: rtl/vga_vram.sv
// VGA frame store: single-beat bus reads/writes (read latency 1) plus an independent scan-out port.
// No back-pressure on either side; out-of-range beats are dropped and read back as zero.
module vga_vram
    import vga_vram_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int FRAME_HW = 4096
) (
    input  logic        sck,
    input  logic        rst,
    vga_vram_if.slave   bus
);

    localparam logic [ADDR_W-1:0] SCAN_LAST = ADDR_W'(FRAME_HW - 1);

    logic              rw;
    logic [HW_W-1:0]   wdat;
    logic [ADDR_HI:0]  addr;
    logic              in_range;
    logic              wr_en;
    logic              rd_en;
    logic              rd_vld;
    logic [HW_W-1:0]   ram_a_rdat;
    logic [HW_W-1:0]   ram_b_rdat;
    logic [ADDR_W-1:0] scan_addr;
    logic              pix_vld;
    logic              frame_start_q;

    assign rw       = bus.mosi[RW_BIT];
    assign wdat     = bus.mosi[DATA_HI:DATA_LO];
    assign addr     = bus.mosi[ADDR_HI:0];
    assign in_range = (addr >> ADDR_W) == '0;

    // Gating with rst keeps beats presented during reset from touching the store.
    assign wr_en = !rst && !bus.cs_n && (rw == RW_WRITE) && in_range;
    assign rd_en = !rst && !bus.cs_n && (rw != RW_WRITE) && in_range;

    vram_dp #(
        .AW (ADDR_W),
        .DW (HW_W)
    ) u_ram (
        .clk    (sck),
        .a_en   (wr_en | rd_en),
        .a_we   (wr_en),
        .a_addr (addr[ADDR_W-1:0]),
        .a_wdat (wdat),
        .a_rdat (ram_a_rdat),
        .b_en   (bus.pix_en & !rst),
        .b_addr (scan_addr),
        .b_rdat (ram_b_rdat)
    );

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_en;
        end
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            scan_addr     <= '0;
            pix_vld       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (bus.pix_en) begin
                pix_vld <= 1'b1;
                if (scan_addr == SCAN_LAST) begin
                    scan_addr     <= '0;
                    frame_start_q <= 1'b1;
                end else begin
                    scan_addr <= scan_addr + 1'b1;
                end
            end
        end
    end

    // RAM output registers cannot be reset, so the reset-able valid flags mask them to zero.
    assign bus.miso        = rd_vld  ? ram_a_rdat : '0;
    assign bus.pix_data    = pix_vld ? ram_b_rdat : '0;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_vram.sv
// Scoreboard bench for vga_vram: a driver pushes per-cycle expectations from an array model,
// a negedge monitor pops and compares miso, pix_data and frame_start.
module tb_vga_vram;
    import vga_vram_pkg::*;

    localparam int ADDR_W   = 12;
    localparam int FRAME_HW = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    typedef struct {
        int          due;
        logic [15:0] miso;
        logic [15:0] pix;
        logic        fs;
    } exp_t;

    logic sck = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t        sb[$];
    logic [15:0] mem_m [DEPTH];
    int          scan_m = 0;
    logic [15:0] pix_m  = 16'h0;

    vga_vram_if bus ();

    vga_vram #(
        .ADDR_W   (ADDR_W),
        .FRAME_HW (FRAME_HW)
    ) dut (
        .sck (sck),
        .rst (rst),
        .bus (bus)
    );

    always #5 sck = ~sck;

    always @(posedge sck) cyc <= cyc + 1;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every output due in this cycle.
    always @(negedge sck) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
            if (sb.size() > 0 && sb[0].due == cyc) begin
                exp_t e;
                e = sb.pop_front();
                check16("miso", bus.miso, e.miso);
                check16("pix_data", bus.pix_data, e.pix);
                check16("frame_start", {15'h0, bus.frame_start}, {15'h0, e.fs});
            end
        end
    end

    // One bus beat plus one scan strobe; expectation derived from the array model.
    task automatic beat(input logic c, input logic w, input logic [18:0] a,
                        input logic [15:0] d, input logic pe);
        exp_t e;
        @(posedge sck);
        #1;
        bus.cs_n   = c;
        bus.mosi   = {w, d, a};
        bus.pix_en = pe;
        e.due  = cyc + 1;
        e.miso = 16'h0;
        if (!c && !w && int'(a) < DEPTH) e.miso = mem_m[a[ADDR_W-1:0]];
        if (pe) begin
            e.pix  = mem_m[scan_m];
            e.fs   = (scan_m == FRAME_HW - 1);
            scan_m = (scan_m + 1) % FRAME_HW;
            pix_m  = e.pix;
        end else begin
            e.pix = pix_m;
            e.fs  = 1'b0;
        end
        if (!c && w && int'(a) < DEPTH) mem_m[a[ADDR_W-1:0]] = d;
        sb.push_back(e);
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        beat(1'b0, 1'b1, 19'(a), d, 1'b0);
    endtask

    task automatic rd(input int a);
        beat(1'b0, 1'b0, 19'(a), 16'h0, 1'b0);
    endtask

    task automatic idle(input logic pe);
        beat(1'b1, 1'b0, 19'h0, 16'h0, pe);
    endtask

    initial begin
        bus.cs_n   = 1'b1;
        bus.mosi   = '0;
        bus.pix_en = 1'b0;
        #1;
        check16("reset_miso", bus.miso, 16'h0);
        check16("reset_pix", bus.pix_data, 16'h0);
        check16("reset_fs", {15'h0, bus.frame_start}, 16'h0);
        @(posedge sck);
        @(posedge sck);
        #1 rst = 1'b0;

        for (int i = 0; i < 64; i++) wr(i, 16'($urandom));

        // Back-to-back reads, then idle returns zero.
        wr(0, 16'h0011); wr(1, 16'h0022); wr(2, 16'h0033);
        rd(0); rd(1); rd(2); idle(1'b0);

        // Read immediately after write.
        wr(5, 16'hBEEF); rd(5); wr(6, 16'h7777); rd(6);

        // Out-of-range write ignored, out-of-range read returns zero.
        wr(0, 16'h1234); wr(4096, 16'hFFFF); rd(0); rd(4096); rd(19'h7FFFF);

        // Full scan passes with frame_start pulses.
        wr(3, 16'h5555);
        for (int i = 0; i < 9; i++) idle(1'b1);

        // Same-edge bus write and scan read of address 3.
        while (scan_m != 3) idle(1'b1);
        beat(1'b0, 1'b1, 19'd3, 16'hAAAA, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        for (int i = 0; i < 2000; i++) begin
            int a;
            a = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4096, 19'h7FFFF))
                                            : int'($urandom_range(0, 63));
            beat(1'($urandom_range(0, 3) == 0), 1'($urandom), 19'(a), 16'($urandom),
                 1'($urandom));
        end

        // Reset mid-stream with a read in flight and the scan counter at 2.
        while (scan_m != 2) idle(1'b1);
        rd(5);
        #2 rst = 1'b1;
        #1;
        check16("midrst_miso", bus.miso, 16'h0);
        check16("midrst_pix", bus.pix_data, 16'h0);
        check16("midrst_fs", {15'h0, bus.frame_start}, 16'h0);
        sb.delete();
        bus.cs_n   = 1'b0;
        bus.mosi   = {1'b1, 16'hDEAD, 19'd7};
        bus.pix_en = 1'b1;
        @(posedge sck);
        @(posedge sck);
        #1;
        rst        = 1'b0;
        bus.cs_n   = 1'b1;
        bus.pix_en = 1'b0;
        scan_m     = 0;
        pix_m      = 16'h0;
        idle(1'b0);
        idle(1'b1);
        rd(7);
        for (int i = 0; i < 200; i++) begin
            beat(1'($urandom_range(0, 3) == 0), 1'($urandom), 19'($urandom_range(0, 63)),
                 16'($urandom), 1'($urandom));
        end
        idle(1'b0);

        repeat (4) @(posedge sck);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_vram.md
VGA_VRAM -- requirements
Module: vga_vram

Interface
REQ-001 Parameter ADDR_W, default 12, half-word address width of the frame store (depth 2**ADDR_W half-words).
REQ-002 Parameter FRAME_HW, default 4096, half-words per frame scanned out, 1 <= FRAME_HW <= 2**ADDR_W.
REQ-003 sck  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cs_n  in  1  chip select from bus, active-low.
REQ-006 mosi  in  36  bus beat: [35] rw (1 = write, 0 = read), [34:19] write half-word, [18:0] half-word address ([0] = half select).
REQ-007 miso  out  16  read half-word returned to bus.
REQ-008 pix_en  in  1  scan-out advance strobe from pixel timing logic.
REQ-009 pix_data  out  16  scanned-out half-word.
REQ-010 frame_start  out  1  one-cycle pulse when scan address wraps to 0.

Function
REQ-011 Each sck cycle with cs_n=0 SHALL be one independent beat; no multi-cycle handshake, no back-pressure.
REQ-012 Write beat (cs_n=0, rw=1, mosi[18:0] < 2**ADDR_W): store mosi[34:19] at address mosi[18:0] on that edge.
REQ-013 Write beat with address >= 2**ADDR_W SHALL be ignored; no store location changes.
REQ-014 Read beat (cs_n=0, rw=0) issued in cycle N SHALL drive the addressed half-word on miso throughout cycle N+1 (latency 1, registered).
REQ-015 Read beat with address >= 2**ADDR_W SHALL return 16'h0000 in cycle N+1.
REQ-016 Cycle after any write beat or any cs_n=1 cycle, miso SHALL be 16'h0000.
REQ-017 Consecutive read beats SHALL return data back-to-back each cycle, in issue order.
REQ-018 Read of an address written in the immediately preceding beat SHALL return the new data.
REQ-019 Scan counter scan_addr (ADDR_W bits): on pix_en=1, pix_data <= store[scan_addr] and scan_addr advances; pix_data holds when pix_en=0.
REQ-020 scan_addr SHALL increment by 1, wrapping FRAME_HW-1 -> 0; frame_start=1 in the cycle after the edge that performed that wrap, else 0.
REQ-021 Simultaneous bus write and scan read to the same address in one cycle: pix_data SHALL receive the old (pre-write) value.
REQ-022 Bus and scan ports SHALL be fully independent; neither stalls the other.
REQ-023 Store contents SHALL NOT be cleared by reset; content after power-up undefined.

Reset
REQ-024 rst=1 SHALL immediately (asynchronously) force miso=16'h0000, pix_data=16'h0000, frame_start=0, scan_addr=0.
REQ-025 Beats and pix_en presented while rst=1 SHALL have no effect; a read in flight at reset assertion SHALL be discarded.
REQ-026 First scan after reset release SHALL read address 0; first frame_start only after wrap.

Structure
REQ-027 Shared package: mosi field positions (RW_BIT=35, DATA_HI=34, DATA_LO=19, ADDR_HI=18), RW_WRITE=1, bus memory-map constant for the VGA window.
REQ-028 One sub-module vram_dp: simple dual-port synchronous RAM (port A read/write with write-first, port B read-only with read-old); vga_vram holds decode, miso register, scan counter, frame_start.

Verification
REQ-029 Write 16'hBEEF to addr 5, next cycle read addr 5 -> miso=16'hBEEF in following cycle.
REQ-030 Read beats to addr 0,1,2 on consecutive cycles after writing 16'h0011/0022/0033 -> miso 0011,0022,0033 on consecutive cycles; cs_n=1 next -> miso=0000.
REQ-031 Write to addr 2**ADDR_W (4096) then read addr 0 (preloaded 16'h1234) -> 1234 unchanged; read addr 4096 -> 0000.
REQ-032 FRAME_HW=4, pix_en held 1 -> pix_data cycles store[0..3] repeatedly; frame_start pulses once every 4 cycles.
REQ-033 Bus write 16'hAAAA to addr 3 (old 16'h5555) on same edge scan reads addr 3 -> pix_data=5555; next scan pass -> AAAA.
REQ-034 Assert rst mid-stream (read in flight, scan_addr=2) -> miso, pix_data, frame_start 0 immediately; after release, first pix_en reads addr 0.
